// File: rtl/edge_point_streamer.sv
// rtl/edge_point_streamer.sv - raster scan of the edge BRAM emitting (x, y) of edge pixels
module edge_point_streamer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [18:0] edge_memory_addr,
    input  logic [3:0]  edge_data,
    output logic        point_valid,
    input  logic        point_ready,
    output logic [9:0]  point_x,
    output logic [8:0]  point_y,
    output logic [18:0] edge_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);
    localparam logic [9:0] X_LAST    = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST    = 9'(HEIGHT - 1);

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic [9:0]  px_q, px_d;
    logic [8:0]  py_q, py_d;
    logic [18:0] addr_q, addr_d;
    logic [18:0] count_q, count_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [1:0]  wait_q, wait_d;
    logic        do_advance;

    // Only bit 0 carries the edge flag.
    logic unused_edge_bits;
    assign unused_edge_bits = ^edge_data[3:1];

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = done_q;
        valid_d    = valid_q;
        px_d       = px_q;
        py_d       = py_q;
        addr_d     = addr_q;
        count_d    = count_q;
        x_d        = x_q;
        y_d        = y_q;
        wait_d     = wait_q;
        do_advance = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    wait_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_CHECK: begin
                if (edge_data[0]) begin
                    px_d    = x_q;
                    py_d    = y_q;
                    valid_d = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    do_advance = 1'b1;
                end
            end
            S_EMIT: begin
                if (point_ready) begin
                    valid_d    = 1'b0;
                    count_d    = count_q + 19'd1;
                    do_advance = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The last pixel leaves the address in place so it still names that pixel.
        if (do_advance) begin
            if (x_q == X_LAST && y_q == Y_LAST) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end else if (x_q == X_LAST) begin
                x_d     = '0;
                y_d     = y_q + 9'd1;
                addr_d  = addr_q + 19'd1;
                state_d = S_WAIT;
            end else begin
                x_d     = x_q + 10'd1;
                addr_d  = addr_q + 19'd1;
                state_d = S_WAIT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            addr_q  <= '0;
            count_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            px_q    <= px_d;
            py_q    <= py_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wait_q  <= wait_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign point_valid      = valid_q;
    assign point_x          = px_q;
    assign point_y          = py_q;
    assign edge_memory_addr = addr_q;
    assign edge_count       = count_q;

endmodule

// File: tb/tb_edge_point_streamer.sv
// tb/tb_edge_point_streamer.sv - directed bench for edge_point_streamer on an 8x4 frame
module tb_edge_point_streamer;

    localparam int W = 8;
    localparam int H = 4;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, point_valid;
    logic        point_ready = 1'b0;
    logic [18:0] edge_memory_addr, edge_count;
    logic [3:0]  edge_data;
    logic [9:0]  point_x;
    logic [8:0]  point_y;

    logic [31:0] mem_bits = '0;
    logic        d1 = 1'b0, d2 = 1'b0;

    int total = 0;
    int bad = 0;

    logic [18:0] pts[$];
    logic        pend = 1'b0;
    logic [9:0]  pend_x;
    logic [8:0]  pend_y;

    always #5 clk = ~clk;

    edge_point_streamer #(.WIDTH(W), .HEIGHT(H), .RD_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .edge_memory_addr(edge_memory_addr), .edge_data(edge_data),
        .point_valid(point_valid), .point_ready(point_ready),
        .point_x(point_x), .point_y(point_y), .edge_count(edge_count)
    );

    // Two-stage BRAM model; upper data bits are always set to prove they are ignored.
    always @(posedge clk) begin
        d1 <= mem_bits[edge_memory_addr[4:0]];
        d2 <= d1;
    end
    assign edge_data = {3'b111, d2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Handshake recorder plus hold-stability check while stalled.
    always @(negedge clk) begin
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("hold_valid", {31'd0, point_valid}, 32'd1);
                chk("hold_xy", {13'd0, point_y, point_x}, {13'd0, pend_y, pend_x});
            end
            if (point_valid && point_ready) pts.push_back({point_y, point_x});
            pend   = point_valid && !point_ready;
            pend_x = point_x;
            pend_y = point_y;
        end
    end

    typedef struct {
        logic [31:0] pattern;
        bit          toggle;
        bit          poke;
        int          exp_count;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[5];

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_scan(input bit toggle, input bit poke, output int cyc);
        cyc = 0;
        pulse_start();
        while (cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (done) break;
            if (toggle) point_ready = ~point_ready;
            if (poke && (cyc % 17 == 5)) start = 1'b1;
        end
        if (!done) chk("scan_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic check_points(input string tag, input logic [31:0] pattern);
        int k;
        k = 0;
        for (int a = 0; a < W * H; a++) begin
            if (pattern[a]) begin
                if (k < pts.size())
                    chk({tag, "_pt"}, {13'd0, pts[k]}, 32'((a / W) * 1024 + (a % W)));
                k++;
            end
        end
        chk({tag, "_npts"}, 32'(pts.size()), 32'(k));
    endtask

    initial begin
        int cyc;
        vecs[0] = '{32'h0000_0000, 1'b0, 1'b0, 0,  96};
        vecs[1] = '{32'h0000_0200, 1'b0, 1'b0, 1,  97};
        vecs[2] = '{32'h8000_0000, 1'b0, 1'b0, 1,  97};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 32, -1};
        vecs[4] = '{32'hA5A5_0F0F, 1'b0, 1'b1, 16, 112};

        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, point_valid}, 32'd0);
        chk("rst_xy", {13'd0, point_y, point_x}, 32'd0);
        chk("rst_addr", {13'd0, edge_memory_addr}, 32'd0);
        chk("rst_count", {13'd0, edge_count}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            mem_bits    = vecs[i].pattern;
            point_ready = 1'b1;
            pts.delete();
            run_scan(vecs[i].toggle, vecs[i].poke, cyc);
            if (vecs[i].exp_cycles >= 0) chk("cycles", 32'(cyc), 32'(vecs[i].exp_cycles));
            chk("count", {13'd0, edge_count}, 32'(vecs[i].exp_count));
            chk("busy_end", {31'd0, busy}, 32'd0);
            chk("done_end", {31'd0, done}, 32'd1);
            chk("addr_end", {13'd0, edge_memory_addr}, 32'd31);
            check_points("vec", vecs[i].pattern);
            repeat (3) @(posedge clk);
            #1;
            chk("done_hold", {31'd0, done}, 32'd1);
        end

        // Stall at address 10 for ten cycles, then accept.
        mem_bits    = 32'h0000_0400;
        point_ready = 1'b0;
        pts.delete();
        pulse_start();
        cyc = 0;
        while (!point_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("stall_valid", {31'd0, point_valid}, 32'd1);
        chk("stall_x", {22'd0, point_x}, 32'd2);
        chk("stall_y", {23'd0, point_y}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_hold_valid", {31'd0, point_valid}, 32'd1);
            chk("stall_hold_x", {22'd0, point_x}, 32'd2);
            chk("stall_hold_y", {23'd0, point_y}, 32'd1);
            chk("stall_count", {13'd0, edge_count}, 32'd0);
        end
        point_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_count_inc", {13'd0, edge_count}, 32'd1);
        chk("stall_valid_drop", {31'd0, point_valid}, 32'd0);
        chk("stall_addr_next", {13'd0, edge_memory_addr}, 32'd11);
        cyc = 0;
        while (!done && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("stall_done", {31'd0, done}, 32'd1);
        chk("stall_final_count", {13'd0, edge_count}, 32'd1);
        check_points("stall", mem_bits);

        // Asynchronous reset while presenting (3, 2).
        mem_bits    = 32'hFFFF_FFFF;
        point_ready = 1'b0;
        pts.delete();
        pulse_start();
        cyc = 0;
        while (cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            point_ready = 1'b0;
            if (point_valid && point_x == 10'd3 && point_y == 9'd2) break;
            if (point_valid) point_ready = 1'b1;
        end
        chk("pre_rst_valid", {31'd0, point_valid}, 32'd1);
        chk("pre_rst_count", {13'd0, edge_count}, 32'd19);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, point_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_count", {13'd0, edge_count}, 32'd0);
        chk("arst_addr", {13'd0, edge_memory_addr}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        pts.delete();
        point_ready = 1'b1;
        run_scan(1'b0, 1'b0, cyc);
        chk("rescan_cycles", 32'(cyc), 32'd128);
        chk("rescan_count", {13'd0, edge_count}, 32'd32);
        check_points("rescan", mem_bits);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
